// File: rtl/vga_scan_timing.sv
// Raster timing for the 80x30 colour text path: pixel coordinates, frame strobe and
// blink phase at zero latency, with sync/enable delayed to match the glyph fetch stage.
module vga_scan_timing #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b0,
    parameter int PIPE_DLY     = 2,
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] posx,
    output logic [8:0] posy,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start,
    output logic       blink
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FW      = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {H_ACT, H_FPR, H_SYN, H_BPR} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FPR, V_SYN, V_BPR} v_state_t;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    h_state_t      h_state;
    v_state_t      v_state;
    logic [FW-1:0] fcnt;
    logic          h_wrap, v_wrap;
    logic          hs_raw, vs_raw, de_raw;

    assign h_wrap = (hcnt == HW'(H_TOTAL - 1));
    assign v_wrap = (vcnt == VW'(V_TOTAL - 1));

    // Region states move one clock ahead of the counter boundary so they stay aligned with hcnt/vcnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt    <= '0;
            vcnt    <= '0;
            h_state <= H_ACT;
            v_state <= V_ACT;
        end else if (en) begin
            if (h_wrap) begin
                hcnt    <= '0;
                h_state <= H_ACT;
                if (v_wrap) begin
                    vcnt    <= '0;
                    v_state <= V_ACT;
                end else begin
                    vcnt <= vcnt + 1'b1;
                    if (vcnt == VW'(V_ACTIVE - 1))
                        v_state <= V_FPR;
                    else if (vcnt == VW'(V_ACTIVE + V_FP - 1))
                        v_state <= V_SYN;
                    else if (vcnt == VW'(V_ACTIVE + V_FP + V_SYNC - 1))
                        v_state <= V_BPR;
                end
            end else begin
                hcnt <= hcnt + 1'b1;
                if (hcnt == HW'(H_ACTIVE - 1))
                    h_state <= H_FPR;
                else if (hcnt == HW'(H_ACTIVE + H_FP - 1))
                    h_state <= H_SYN;
                else if (hcnt == HW'(H_ACTIVE + H_FP + H_SYNC - 1))
                    h_state <= H_BPR;
            end
        end
    end

    assign active      = (h_state == H_ACT) && (v_state == V_ACT);
    assign posx        = (h_state == H_ACT) ? 10'(hcnt) : 10'd0;
    assign posy        = (v_state == V_ACT) ? 9'(vcnt) : 9'd0;
    assign frame_start = en && (hcnt == '0) && (vcnt == '0);

    assign hs_raw = (h_state == H_SYN) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = (v_state == V_SYN) ? SYNC_POL : ~SYNC_POL;
    assign de_raw = active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            blink <= 1'b0;
        end else if (frame_start) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                blink <= ~blink;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign hsync = hs_raw;
            assign vsync = vs_raw;
            assign de    = de_raw;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_p, vs_p, de_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_p <= {PIPE_DLY{~SYNC_POL}};
                    vs_p <= {PIPE_DLY{~SYNC_POL}};
                    de_p <= '0;
                end else if (en) begin
                    hs_p[0] <= hs_raw;
                    vs_p[0] <= vs_raw;
                    de_p[0] <= de_raw;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_p[i] <= hs_p[i-1];
                        vs_p[i] <= vs_p[i-1];
                        de_p[i] <= de_p[i-1];
                    end
                end
            end

            assign hsync = hs_p[PIPE_DLY-1];
            assign vsync = vs_p[PIPE_DLY-1];
            assign de    = de_p[PIPE_DLY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: one default-timing instance plus two reduced-raster instances,
// checked against a table of hand-derived points and an arithmetic reference model.
module tb_vga_scan_timing;
    typedef struct {
        int   ha, hf, hw, hb, va, vf, vw, vb;
        logic pol;
        int   dly, bf;
    } cfg_t;

    typedef struct {
        int         cyc;
        logic [9:0] posx;
        logic [8:0] posy;
        logic       act, de, hs, fs;
    } vec_t;

    localparam int NV = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] a_posx, b_posx, c_posx;
    logic [8:0] a_posy, b_posy, c_posy;
    logic a_active, a_hsync, a_vsync, a_de, a_frame_start, a_blink;
    logic b_active, b_hsync, b_vsync, b_de, b_frame_start, b_blink;
    logic c_active, c_hsync, c_vsync, c_de, c_frame_start, c_blink;

    vga_scan_timing dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .posx(a_posx), .posy(a_posy), .active(a_active),
        .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .frame_start(a_frame_start), .blink(a_blink)
    );

    vga_scan_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
        .V_BP(2), .SYNC_POL(1'b0), .PIPE_DLY(2), .BLINK_FRAMES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .posx(b_posx), .posy(b_posy), .active(b_active),
        .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .frame_start(b_frame_start), .blink(b_blink)
    );

    vga_scan_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
        .V_BP(2), .SYNC_POL(1'b1), .PIPE_DLY(0), .BLINK_FRAMES(1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .posx(c_posx), .posy(c_posy), .active(c_active),
        .hsync(c_hsync), .vsync(c_vsync), .de(c_de), .frame_start(c_frame_start), .blink(c_blink)
    );

    cfg_t ca, cb, cc;
    vec_t tbl[NV];
    int   t = 0;
    int   ti = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   use_tbl = 1'b0;

    // Position follows directly from the count of enabled clocks since reset
    function automatic logic [24:0] model(input cfg_t c, input int tt, input logic e);
        int ht, vt, ft, h, v, hd, vd, n;
        logic act, hs, vs, d, fs, bl;
        logic [9:0] px;
        logic [8:0] py;
        ht  = c.ha + c.hf + c.hw + c.hb;
        vt  = c.va + c.vf + c.vw + c.vb;
        ft  = ht * vt;
        h   = tt % ht;
        v   = (tt / ht) % vt;
        act = (h < c.ha) && (v < c.va);
        px  = (h < c.ha) ? 10'(h) : 10'd0;
        py  = (v < c.va) ? 9'(v) : 9'd0;
        fs  = e && (h == 0) && (v == 0);
        n   = (tt + ft - 1) / ft;
        bl  = ((n / c.bf) % 2) == 1;
        if (tt >= c.dly) begin
            hd = (tt - c.dly) % ht;
            vd = ((tt - c.dly) / ht) % vt;
            hs = (hd >= c.ha + c.hf && hd < c.ha + c.hf + c.hw) ? c.pol : ~c.pol;
            vs = (vd >= c.va + c.vf && vd < c.va + c.vf + c.vw) ? c.pol : ~c.pol;
            d  = (hd < c.ha) && (vd < c.va);
        end else begin
            hs = ~c.pol;
            vs = ~c.pol;
            d  = 1'b0;
        end
        return {px, py, act, hs, vs, d, fs, bl};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d en=%0b rst_n=%0b: got %h, expected %h", name, t, en, rst_n, got, exp);
        end
    endtask

    task automatic check_all();
        chk("dut_a_model", 32'({a_posx, a_posy, a_active, a_hsync, a_vsync, a_de, a_frame_start, a_blink}),
            32'(model(ca, t, en)));
        chk("dut_b_model", 32'({b_posx, b_posy, b_active, b_hsync, b_vsync, b_de, b_frame_start, b_blink}),
            32'(model(cb, t, en)));
        chk("dut_c_model", 32'({c_posx, c_posy, c_active, c_hsync, c_vsync, c_de, c_frame_start, c_blink}),
            32'(model(cc, t, en)));
        chk("dut_c_de_eq_active", 32'(c_de), 32'(c_active));
        if (use_tbl && rst_n && ti < NV && tbl[ti].cyc == t) begin
            chk($sformatf("tbl_a_cyc%0d", t),
                32'({a_posx, a_posy, a_active, a_de, a_hsync, a_frame_start}),
                32'({tbl[ti].posx, tbl[ti].posy, tbl[ti].act, tbl[ti].de, tbl[ti].hs, tbl[ti].fs}));
            ti++;
        end
    endtask

    task automatic step(input logic e);
        @(negedge clk);
        en = e;
        #1;
        check_all();
        @(posedge clk);
        if (en && rst_n) t++;
    endtask

    initial begin
        ca = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2, 16};
        cb = '{16, 2, 3, 3, 6, 1, 2, 2, 1'b0, 2, 2};
        cc = '{16, 2, 3, 3, 6, 1, 2, 2, 1'b1, 0, 1};

        // cycle, posx, posy, active, de, hsync, frame_start for the default raster
        tbl[0]  = '{0,    10'd0,   9'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1,    10'd1,   9'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2,    10'd2,   9'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{639,  10'd639, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{640,  10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{641,  10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{642,  10'd0,   9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{657,  10'd0,   9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{658,  10'd0,   9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{753,  10'd0,   9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{754,  10'd0,   9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{800,  10'd0,   9'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{802,  10'd2,   9'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1439, 10'd639, 9'd1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Held in reset: frame_start tracks en, everything else idle
        repeat (3) step(1'b0);
        repeat (2) step(1'b1);
        #2 rst_n = 1'b1;

        use_tbl = 1'b1;
        repeat (1500) step(1'b1);
        use_tbl = 1'b0;
        chk("tbl_points_reached", 32'(ti), 32'(NV));

        repeat (3000) step($urandom_range(0, 3) != 0);
        for (int i = 0; i < 1000; i++) step(i % 2 == 0);

        // Restart, reach blink=1 on the reduced raster, then reset mid-line
        @(negedge clk);
        #2 rst_n = 1'b0;
        t = 0;
        repeat (2) step(1'b1);
        #2 rst_n = 1'b1;
        repeat (264 + 12) step(1'b1);
        @(negedge clk);
        #2;
        chk("b_blink_before_rst", 32'(b_blink), 32'd1);
        chk("b_posx_mid_line", 32'(b_posx), 32'd12);
        rst_n = 1'b0;
        #1;
        t = 0;
        chk("b_blink_async_rst", 32'(b_blink), 32'd0);
        chk("b_hsync_async_rst", 32'(b_hsync), 32'd1);
        chk("b_de_async_rst", 32'(b_de), 32'd0);
        chk("b_posx_async_rst", 32'(b_posx), 32'd0);
        chk("a_hsync_async_rst", 32'(a_hsync), 32'd1);
        chk("a_de_async_rst", 32'(a_de), 32'd0);
        repeat (3) step(1'b1);
        #2 rst_n = 1'b1;
        repeat (700) step($urandom_range(0, 1) == 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_scan_timing.md
# vga_scan_timing

Raster timing generator for the 80x30 colour text path. Produces the pixel coordinates `posx`/`posy` consumed by the downstream character/colour fetch stage, plus sync and display-enable outputs delayed to line up with that stage's registered pixel output. It also supplies a frame-start strobe and a slow blink phase used for attribute blinking and the cursor.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in clocks.
- `H_SYNC`, 96: horizontal sync width, in clocks.
- `H_BP`, 48: horizontal back porch, in clocks.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: asserted level of `hsync` and `vsync`.
- `PIPE_DLY`, 2: delay in enabled clocks applied to `hsync`, `vsync` and `de`; legal range 0..7.
- `BLINK_FRAMES`, 16: frames per `blink` half-period; must be at least 1.

Ports (clock and reset first):
- `clk`  in  1  pixel clock; one clock, all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  pixel advance enable; when 0, all state holds.
- `posx`  out  10  horizontal pixel coordinate.
- `posy`  out  9  vertical pixel coordinate.
- `active`  out  1  undelayed visible-region flag.
- `hsync`  out  1  horizontal sync, delayed by `PIPE_DLY`.
- `vsync`  out  1  vertical sync, delayed by `PIPE_DLY`.
- `de`  out  1  display enable, delayed by `PIPE_DLY`.
- `frame_start`  out  1  one-clock strobe at the first pixel of a frame.
- `blink`  out  1  blink phase.

## Operation
- Counters:
  - `hcnt` runs 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
  - `vcnt` runs 0..V_TOTAL-1, with V_TOTAL = 525 by default.
  - Both advance only on clocks where `en`=1.
  - `hcnt` wraps to 0 at H_TOTAL-1. `vcnt` increments only on that same wrap clock and wraps to 0 at V_TOTAL-1.
- Horizontal region FSM, derived from `hcnt`:
  - H_ACT: 0..639.
  - H_FPR: 640..655.
  - H_SYN: 656..751.
  - H_BPR: 752..799, then back to H_ACT.
- Vertical region FSM, same scheme on `vcnt`:
  - V_ACT: 0..479.
  - V_FPR: 480..489.
  - V_SYN: 490..491.
  - V_BPR: 492..524.
- `active` = H_ACT and V_ACT.
- `posx` = `hcnt` during H_ACT, otherwise 0. `posy` = `vcnt` during V_ACT, otherwise 0. Within active, `posx` bits [9:3] give the column (0..79) and `posy` bits [8:4] give the row (0..29).
- Raw sync and enable:
  - Raw hsync is at `SYNC_POL` during H_SYN, otherwise `~SYNC_POL`.
  - Raw vsync follows the same rule during V_SYN; it is independent of horizontal region.
  - Raw de = `active`.
- Delay line: raw hsync/vsync/de pass through a `PIPE_DLY`-deep shift register that advances only when `en`=1. With `PIPE_DLY`=0 the outputs are combinational from the counters.
- `frame_start` = 1 for exactly one clock when `en`=1 and `hcnt`=0 and `vcnt`=0. It is never asserted while `en`=0.
- Blink:
  - A frame counter increments on each `frame_start`.
  - On reaching BLINK_FRAMES-1 it clears and `blink` toggles.
- Reset (asynchronous on `rst_n` low, mid-line or mid-frame alike):
  - `hcnt`, `vcnt`, frame counter and `blink` go to 0.
  - Every delay stage loads idle values: sync = `~SYNC_POL`, de = 0.
- Outputs during and immediately after reset:
  - `posx`=0, `posy`=0, `active`=1 (the counters sit at pixel 0,0).
  - `hsync`=`vsync`=`~SYNC_POL`, `de`=0, `blink`=0.
  - `frame_start` follows `en`.
- First frame after reset release starts at pixel (0,0). There is no partial frame.

## Timing
- `posx`, `posy`, `active` and `frame_start` are combinational from registered counters: zero latency.
- `hsync`, `vsync` and `de` lag the counter state by exactly `PIPE_DLY` enabled clocks.
  - The default of 2 matches the downstream stage's character-latch plus glyph-lookup delay.
- Simultaneous wraps: at `hcnt`=799, `vcnt`=524 with `en`=1, both counters go to 0 on the same edge. `frame_start` asserts on the following clock, provided `en`=1 then.
- `en` low for N clocks stretches every interval by N. No counter, delay stage or blink state changes while `en`=0.

## Test plan
- Reset release with `en`=1 held, default parameters:
  - First cycle: `posx`=0, `posy`=0, `active`=1, `frame_start`=1.
  - `de` rises 2 clocks later.
  - `hsync` falls at clock 656+2 and stays low for 96 clocks.
- Run one full frame:
  - `frame_start` recurs every 420000 clocks.
  - `vsync` low for exactly 1600 clocks, starting at clock 490*800+2.
  - `de` high for 640 clocks on each of 480 lines, 307200 in total.
- Coordinate check:
  - At `hcnt`=639, `vcnt`=479: `posx`=639, `posy`=479.
  - Next clock: `posx`=0, `posy`=479, `active`=0.
- Toggle `en` 1/0 every clock:
  - Line period becomes 1600 clocks.
  - `hsync` width 192 clocks.
  - `frame_start` pulses are one clock wide, never on an `en`=0 clock.
- Blink with `BLINK_FRAMES`=2:
  - `blink` toggles every 2nd `frame_start`.
  - Reach `blink`=1, then assert `rst_n`=0 mid-line at `hcnt`=300: `blink`=0, `hsync`=1 and `de`=0 immediately, asynchronously to `clk`.
- Parameters `SYNC_POL`=1, `PIPE_DLY`=0:
  - `hsync` high exactly for `hcnt` 656..751, with no lag.
  - `de` equals `active` on every clock.
